// File: rtl/quad_decoder_if.sv
// Host-side bus of the quadrature decoder: load/clear controls in, position/status out.
interface quad_decoder_if #(
  parameter int CNT_W = 16
);
  logic             load;
  logic [CNT_W-1:0] d_in;
  logic             err_clr;
  logic [CNT_W-1:0] position;
  logic             dir;
  logic             step_valid;
  logic             err;

  modport master (
    output load, d_in, err_clr,
    input  position, dir, step_valid, err
  );

  modport slave (
    input  load, d_in, err_clr,
    output position, dir, step_valid, err
  );
endinterface

// File: rtl/quad_decoder.sv
// Quadrature encoder decoder: 2-flop sync, FILT_LEN-sample level filter, phase FSM, position counter.
// Optional index-pulse clear enabled by defining QDEC_INDEX_EN (adds input i_enc_idx).
module quad_decoder #(
  parameter int CNT_W    = 16,
  parameter int FILT_LEN = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_enc_a,
  input  logic            i_enc_b,
`ifdef QDEC_INDEX_EN
  input  logic            i_enc_idx,
`endif
  quad_decoder_if.slave   bus
);

  localparam logic [1:0] S00 = 2'b00;
  localparam logic [1:0] S01 = 2'b01;
  localparam logic [1:0] S11 = 2'b11;
  localparam logic [1:0] S10 = 2'b10;

  localparam logic [3:0] FILT_MAX = 4'(FILT_LEN);

  // Next phase in the up direction (A leads B).
  function automatic logic [1:0] up_next(input logic [1:0] s);
    logic [1:0] n;
    case (s)
      S00:     n = S10;
      S10:     n = S11;
      S11:     n = S01;
      S01:     n = S00;
      default: n = S00;
    endcase
    return n;
  endfunction

  logic             r_a_meta, r_a_sync;
  logic             r_b_meta, r_b_sync;
  logic [1:0]       w_ab_sync;

  logic [1:0]       r_cand;
  logic [3:0]       r_cnt;
  logic [1:0]       r_filt;
  logic             r_fvalid;
  logic             r_fnew;
  logic             w_emit;

  logic [1:0]       r_state;
  logic             r_init;
  logic [CNT_W-1:0] r_position;
  logic             r_dir;
  logic             r_step_valid;
  logic             r_err;

  logic [1:0]       w_diff;
  logic             w_step;
  logic             w_illegal;
  logic             w_up;
  logic             w_idx_clr;
  logic [CNT_W-1:0] w_position_nxt;
  logic             w_dir_nxt;
  logic             w_step_valid_nxt;
  logic             w_err_nxt;

  assign w_ab_sync = {r_a_sync, r_b_sync};

  // Two-flop synchronizers for the asynchronous encoder phases.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a_meta <= 1'b0;
      r_a_sync <= 1'b0;
      r_b_meta <= 1'b0;
      r_b_sync <= 1'b0;
    end else begin
      r_a_meta <= i_enc_a;
      r_a_sync <= r_a_meta;
      r_b_meta <= i_enc_b;
      r_b_sync <= r_b_meta;
    end
  end

  // A candidate level is accepted once, after FILT_LEN identical samples; the
  // first acceptance after reset is forced even if it equals the cleared level.
  assign w_emit = (r_cnt == FILT_MAX) && (!r_fvalid || (r_cand != r_filt));

  // Level filter: count consecutive identical samples and publish accepted levels.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cand   <= 2'b00;
      r_cnt    <= 4'd0;
      r_filt   <= 2'b00;
      r_fvalid <= 1'b0;
      r_fnew   <= 1'b0;
    end else begin
      if (w_ab_sync != r_cand) begin
        r_cand <= w_ab_sync;
        r_cnt  <= 4'd1;
      end else if (r_cnt != FILT_MAX) begin
        r_cnt <= r_cnt + 4'd1;
      end
      if (w_emit) begin
        r_filt   <= r_cand;
        r_fvalid <= 1'b1;
      end
      r_fnew <= w_emit;
    end
  end

`ifdef QDEC_INDEX_EN
  logic r_idx_meta, r_idx_sync, r_idx_prev;

  // Index synchronizer plus edge-detect history.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx_meta <= 1'b0;
      r_idx_sync <= 1'b0;
      r_idx_prev <= 1'b0;
    end else begin
      r_idx_meta <= i_enc_idx;
      r_idx_sync <= r_idx_meta;
      r_idx_prev <= r_idx_sync;
    end
  end

  assign w_idx_clr = r_idx_sync && !r_idx_prev && (r_state == S00) && !r_init;
`else
  assign w_idx_clr = 1'b0;
`endif

  assign w_diff    = r_filt ^ r_state;
  assign w_step    = r_fnew && !r_init && (^w_diff);
  assign w_illegal = r_fnew && !r_init && (&w_diff);
  assign w_up      = (up_next(r_state) == r_filt);

  // Next-state of the host-visible outputs: load beats index beats step; err set beats clear.
  always_comb begin
    w_position_nxt   = r_position;
    w_dir_nxt        = r_dir;
    w_step_valid_nxt = 1'b0;
    w_err_nxt        = r_err;
    if (bus.load) begin
      w_position_nxt = bus.d_in;
    end else if (w_idx_clr) begin
      w_position_nxt = '0;
    end else if (w_step) begin
      if (w_up) begin
        w_position_nxt = r_position + CNT_W'(1);
      end else begin
        w_position_nxt = r_position - CNT_W'(1);
      end
    end else begin
      w_position_nxt = r_position;
    end
    if (w_step && !bus.load) begin
      w_dir_nxt        = w_up;
      w_step_valid_nxt = 1'b1;
    end else begin
      w_dir_nxt        = r_dir;
      w_step_valid_nxt = 1'b0;
    end
    if (w_illegal) begin
      w_err_nxt = 1'b1;
    end else if (bus.err_clr) begin
      w_err_nxt = 1'b0;
    end else begin
      w_err_nxt = r_err;
    end
  end

  // Phase state, INIT flag and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S00;
      r_init       <= 1'b1;
      r_position   <= '0;
      r_dir        <= 1'b0;
      r_step_valid <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      if (r_fnew) begin
        r_state <= r_filt;
        r_init  <= 1'b0;
      end
      r_position   <= w_position_nxt;
      r_dir        <= w_dir_nxt;
      r_step_valid <= w_step_valid_nxt;
      r_err        <= w_err_nxt;
    end
  end

  assign bus.position   = r_position;
  assign bus.dir        = r_dir;
  assign bus.step_valid = r_step_valid;
  assign bus.err        = r_err;

endmodule

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 Parameter CNT_W, default 16, sets the width of the position counter and the load value.
REQ-002 Parameter FILT_LEN, default 3, range 1..8, is the number of consecutive equal synchronized samples needed to accept a new A/B level.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 enc_a, enc_b  input  1 each  quadrature encoder phases, asynchronous to clk.
REQ-006 load  input  1  when high, position is loaded from d_in.
REQ-007 d_in  input  CNT_W  load value.
REQ-008 err_clr  input  1  clears the sticky err flag.
REQ-009 position  output  CNT_W  registered position count.
REQ-010 dir  output  1  direction of the last accepted step; 1 = up, 0 = down.
REQ-011 step_valid  output  1  one-cycle pulse on each accepted legal step.
REQ-012 err  output  1  sticky flag for an illegal transition, where both phases changed at once.

Function
REQ-013 enc_a and enc_b SHALL each pass through a 2-flop synchronizer before any other logic.
REQ-014 The filter SHALL update the filtered {A,B} only after FILT_LEN consecutive identical synchronized samples; shorter pulses SHALL be ignored.
REQ-015 Phase state machine: states S00, S01, S11, S10, encoded as the filtered {A,B}, plus an INIT flag.
REQ-016 Up sequence: S00->S10->S11->S01->S00, i.e. A leads B; the reverse order is down.
REQ-017 On a legal up step: position +1 (mod 2^CNT_W), dir=1, step_valid=1 for one cycle.
REQ-018 On a legal down step: position -1 (mod 2^CNT_W), dir=0, step_valid=1 for one cycle.
REQ-019 Wrap-around: all-ones +1 gives 0; 0 -1 gives all-ones; no saturation, no flag.
REQ-020 Illegal step, where both bits change: err=1, position and dir unchanged, step_valid=0, and the state machine adopts the new filtered state.
REQ-021 INIT: the first filtered sample after reset SHALL set the state without counting, flagging or pulsing step_valid.
REQ-022 Latency: an A/B level first sampled at edge N and held stable SHALL update position and step_valid at edge N+FILT_LEN+3.
REQ-023 Priority within one cycle: load > step.
  - When load and a step coincide, position = d_in and step_valid=0.
  - The state machine still advances; dir is unchanged.
REQ-024 err_clr SHALL clear err on the next edge.
  - When err_clr and a new illegal step coincide, err SHALL remain 1 (set wins).
REQ-025 Filtered-level changes SHALL be accepted at most once per clock; consecutive accepted steps SHALL be at least FILT_LEN clocks apart by construction.

Reset
REQ-026 When rst_n=0 at a rising clk edge, the block SHALL reset as follows:
  - position=0, dir=0, step_valid=0, err=0.
  - Synchronizer and filter registers cleared to 0.
  - INIT flag set.
REQ-027 Reset SHALL take priority over load, step and err_clr.
REQ-028 Reset asserted mid-sequence SHALL discard any pending filtered transition; the next accepted sample SHALL be treated per REQ-021.

Configuration
REQ-029 Macro QDEC_INDEX_EN:
  - Defined: adds input enc_idx (1 bit, asynchronous), 2-flop synchronized, no filter.
  - A synchronized rising edge of enc_idx while the state is S00 SHALL clear position to 0 on the next edge.
  - Priority: load > index > step; an index clear coinciding with a step gives position=0 and step_valid=1.
  - Not defined: no enc_idx port and no index logic; behaviour otherwise identical.

Verification
REQ-030 Reset, then drive A/B through 00,10,11,01,00 with each level held 10 clks (FILT_LEN=3) -> position=4, dir=1, exactly 4 step_valid pulses, each at edge N+6.
REQ-031 With position=0, drive one down step 00->01 -> position=16'hFFFF, dir=0; load with d_in=16'hFFFF, then one up step -> position=0.
REQ-032 Glitch test: 2-clk pulse on enc_a from state S00 with FILT_LEN=3 -> no position change, no step_valid, err=0.
REQ-033 Jump 00->11 held 10 clks -> err=1, position unchanged; err_clr for 1 clk -> err=0; err_clr coinciding with a further 11->00 jump -> err stays 1.
REQ-034 load=1 with d_in=16'h1234 in the same cycle as an accepted up step -> position=16'h1234, step_valid=0; the next up step -> 16'h1235.
REQ-035 QDEC_INDEX_EN defined, position=16'h0042, state S00, pulse enc_idx -> position=0; the same pulse in state S11 -> no change.
